// File: rtl/jtkicker_romslot_if.sv
// jtkicker_romslot_if: 32-bit ROM consumer bus plus 16-bit SDRAM arbiter port
//   rom_cs/rom_addr -> rom_data/rom_ok          consumer side
//   sdram_req/sdram_addr <- sdram_ack/dst/din   arbiter side
//   slave modport = the ROM slot, master modport = consumer + SDRAM controller
interface jtkicker_romslot_if #(
    parameter int AW       = 14,
    parameter int SDRAM_AW = 22
);
    logic                rom_cs;
    logic [AW-1:0]       rom_addr;
    logic [31:0]         rom_data;
    logic                rom_ok;
    logic                sdram_req;
    logic [SDRAM_AW-1:0] sdram_addr;
    logic                sdram_ack;
    logic                sdram_dst;
    logic [15:0]         sdram_din;
    modport slave (
        input  rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_din,
        output rom_data, rom_ok, sdram_req, sdram_addr
    );
    modport master (
        output rom_cs, rom_addr, sdram_ack, sdram_dst, sdram_din,
        input  rom_data, rom_ok, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtkicker_romslot.sv
// jtkicker_romslot: single-entry cached 32-bit ROM reader built from two 16-bit SDRAM beats
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of jtkicker_romslot_if (consumer request + SDRAM arbiter port)
module jtkicker_romslot #(
    parameter int                  AW       = 14,
    parameter int                  SDRAM_AW = 22,
    parameter logic [SDRAM_AW-1:0] OFFSET   = '0
) (
    input logic                clk,
    input logic                rst,
    jtkicker_romslot_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, REQ, BEAT0, BEAT1} state_t;
    state_t              state_q, state_d;
    logic [AW-1:0]       fetch_q, fetch_d, cached_q, cached_d;
    logic                valid_q, valid_d, req_q, req_d;
    logic [15:0]         lo_q, lo_d;
    logic [31:0]         data_q, data_d;
    logic [SDRAM_AW-1:0] saddr_q, saddr_d, miss_addr;
    logic                hit;
    // two 16-bit words per 32-bit word; the sum wraps at the SDRAM address width
    assign miss_addr      = OFFSET + SDRAM_AW'({bus.rom_addr, 1'b0});
    assign hit            = bus.rom_cs & valid_q & (bus.rom_addr == cached_q);
    assign bus.rom_ok     = hit;
    assign bus.rom_data   = data_q;
    assign bus.sdram_req  = req_q;
    assign bus.sdram_addr = saddr_q;
    always_comb begin
        state_d  = state_q;
        fetch_d  = fetch_q;
        cached_d = cached_q;
        valid_d  = valid_q;
        req_d    = req_q;
        lo_d     = lo_q;
        data_d   = data_q;
        saddr_d  = saddr_q;
        case (state_q)
            IDLE: if (bus.rom_cs && !hit) begin
                fetch_d = bus.rom_addr;
                saddr_d = miss_addr;
                req_d   = 1'b1;
                valid_d = 1'b0;
                state_d = REQ;
            end
            REQ: if (bus.sdram_ack) begin
                req_d = 1'b0;
                // a beat coinciding with the ack is the first half
                lo_d    = bus.sdram_dst ? bus.sdram_din : lo_q;
                state_d = bus.sdram_dst ? BEAT1 : BEAT0;
            end
            BEAT0: if (bus.sdram_dst) begin
                lo_d    = bus.sdram_din;
                state_d = BEAT1;
            end
            BEAT1: if (bus.sdram_dst) begin
                data_d   = {bus.sdram_din, lo_q};
                cached_d = fetch_q;
                valid_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            fetch_q  <= '0;
            cached_q <= '0;
            valid_q  <= 1'b0;
            req_q    <= 1'b0;
            lo_q     <= '0;
            data_q   <= '0;
            saddr_q  <= '0;
        end else begin
            state_q  <= state_d;
            fetch_q  <= fetch_d;
            cached_q <= cached_d;
            valid_q  <= valid_d;
            req_q    <= req_d;
            lo_q     <= lo_d;
            data_q   <= data_d;
            saddr_q  <= saddr_d;
        end
    end
endmodule

// File: tb/tb_jtkicker_romslot.sv
// tb_jtkicker_romslot: directed and randomized checks of jtkicker_romslot against a cache model
module tb_jtkicker_romslot;
    localparam logic [21:0] OFF  = 22'h10000;
    localparam logic [21:0] OFF2 = 22'h3FFFFE;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    jtkicker_romslot_if #(.AW(14), .SDRAM_AW(22)) bus ();
    jtkicker_romslot_if #(.AW(14), .SDRAM_AW(22)) bus2 ();
    jtkicker_romslot #(.AW(14), .SDRAM_AW(22), .OFFSET(OFF)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    jtkicker_romslot #(.AW(14), .SDRAM_AW(22), .OFFSET(OFF2)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    int n_checks = 0;
    int n_fail   = 0;
    logic        m_valid;
    logic [13:0] m_cached, m_fetch;
    logic [31:0] m_data;
    logic [13:0] pool [4] = '{14'h0123, 14'h0124, 14'h3FFF, 14'h0000};

    function automatic logic [21:0] exp_saddr(input logic [21:0] off, input logic [13:0] a);
        return 22'((longint'(off) + 2 * longint'(a)) % (64'd1 << 22));
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input string tag);
        #1;
        check({tag, "_ok"}, bus.rom_ok, bus.rom_cs && m_valid && bus.rom_addr == m_cached);
        check({tag, "_data"}, bus.rom_data, m_data);
    endtask

    // consumer has presented a miss; the next edge must raise the request
    task automatic start_miss(input string tag);
        tick();
        check({tag, "_req"}, bus.sdram_req, 1);
        check({tag, "_saddr"}, bus.sdram_addr, exp_saddr(OFF, bus.rom_addr));
        m_fetch = bus.rom_addr;
        m_valid = 1'b0;
    endtask

    // ad: cycles before ack, g0: cycles from ack to first beat (0 = same cycle), g1: gap between beats
    task automatic serve(input int ad, input int g0, input int g1, input logic [15:0] lo, input logic [15:0] hi);
        for (int i = 0; i < ad; i++) begin
            check("req_hold", bus.sdram_req, 1);
            check("ok_busy", bus.rom_ok, 0);
            tick();
        end
        bus.sdram_ack = 1'b1;
        if (g0 == 0) begin
            bus.sdram_dst = 1'b1;
            bus.sdram_din = lo;
        end
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b0;
        check("req_drop", bus.sdram_req, 0);
        if (g0 != 0) begin
            repeat (g0 - 1) tick();
            bus.sdram_dst = 1'b1;
            bus.sdram_din = lo;
            tick();
            bus.sdram_dst = 1'b0;
        end
        for (int i = 0; i < g1; i++) begin
            check("ok_gap", bus.rom_ok, 0);
            check("req_gap", bus.sdram_req, 0);
            tick();
        end
        bus.sdram_dst = 1'b1;
        bus.sdram_din = hi;
        tick();
        bus.sdram_dst = 1'b0;
        m_data   = {hi, lo};
        m_cached = m_fetch;
        m_valid  = 1'b1;
    endtask

    initial begin
        bus.rom_cs = 1'b1; bus.rom_addr = '0;
        bus.sdram_ack = 1'b0; bus.sdram_dst = 1'b0; bus.sdram_din = '0;
        bus2.rom_cs = 1'b0; bus2.rom_addr = '0;
        bus2.sdram_ack = 1'b0; bus2.sdram_dst = 1'b0; bus2.sdram_din = '0;
        m_valid = 1'b0; m_cached = '0; m_fetch = '0; m_data = '0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ok", bus.rom_ok, 0);
        check("rst_req", bus.sdram_req, 0);
        check("rst_data", bus.rom_data, 0);
        check("rst_saddr", bus.sdram_addr, 0);
        rst = 1'b0;
        start_miss("post_rst");
        serve(1, 1, 0, 16'h1111, 16'h2222);
        probe("post_rst_fill");
        // miss and fill with the reference beats
        bus.rom_addr = 14'h0123;
        probe("mf_pre");
        start_miss("mf");
        serve(2, 1, 0, 16'hBEEF, 16'hDEAD);
        check("mf_ok", bus.rom_ok, 1);
        check("mf_data", bus.rom_data, 32'hDEADBEEF);
        for (int i = 0; i < 20; i++) begin
            check("hit_ok", bus.rom_ok, 1);
            check("hit_req", bus.sdram_req, 0);
            tick();
        end
        bus.rom_addr = 14'h0124;
        #1;
        check("chg_ok_drop", bus.rom_ok, 0);
        start_miss("chg");
        check("chg_saddr_abs", bus.sdram_addr, 22'h10248);
        serve(0, 1, 2, 16'h0A0B, 16'h0C0D);
        probe("chg_fill");
        // address moves while the fetch is in flight
        bus.rom_addr = 14'h0001;
        probe("mid_pre");
        start_miss("mid");
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.rom_addr = 14'h0002;
        bus.sdram_dst = 1'b1; bus.sdram_din = 16'h5678;
        tick();
        bus.sdram_din = 16'h9ABC;
        tick();
        bus.sdram_dst = 1'b0;
        m_data = 32'h9ABC5678; m_cached = 14'h0001; m_valid = 1'b1;
        probe("mid_done");
        start_miss("mid_second");
        serve(1, 2, 1, 16'h3333, 16'h4444);
        probe("mid_second_fill");
        // reset while waiting for the second beat
        bus.rom_addr = 14'h0005;
        probe("rmid_pre");
        start_miss("rmid");
        bus.sdram_ack = 1'b1;
        tick();
        bus.sdram_ack = 1'b0;
        bus.sdram_dst = 1'b1; bus.sdram_din = 16'hAAAA;
        tick();
        bus.sdram_dst = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_valid = 1'b0; m_cached = '0; m_data = '0;
        bus.rom_cs = 1'b0;
        bus.sdram_dst = 1'b1; bus.sdram_din = 16'h1234;
        tick();
        bus.sdram_dst = 1'b0;
        check("rmid_req", bus.sdram_req, 0);
        check("rmid_data", bus.rom_data, 0);
        tick();
        check("rmid_idle_req", bus.sdram_req, 0);
        bus.rom_cs = 1'b1;
        probe("rmid_after");
        start_miss("rmid_refetch");
        serve(0, 0, 0, 16'h5555, 16'h6666);
        probe("rmid_refill");
        // randomized traffic against the model
        for (int it = 0; it < 200; it++) begin
            bus.rom_cs   = ($urandom_range(0, 7) != 0);
            bus.rom_addr = pool[$urandom_range(0, 3)];
            probe("rnd");
            if (bus.rom_cs && !(m_valid && bus.rom_addr == m_cached)) begin
                start_miss("rnd");
                serve($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                      16'($urandom), 16'($urandom));
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.sdram_dst = 1'b1;
                    bus.sdram_ack = 1'($urandom);
                    bus.sdram_din = 16'($urandom);
                end
                tick();
                bus.sdram_dst = 1'b0;
                bus.sdram_ack = 1'b0;
                check("rnd_idle_req", bus.sdram_req, 0);
            end
        end
        // address arithmetic wraps at the SDRAM width
        bus2.rom_cs = 1'b1;
        bus2.rom_addr = 14'h0001;
        tick();
        check("wrap_req", bus2.sdram_req, 1);
        check("wrap_saddr", bus2.sdram_addr, 22'h000000);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
